// File: rtl/udma_ctrl_mc.sv
// -----------------------------------------------------------------------------
// udma_ctrl_mc
// Top-level control block of the uDMA subsystem. Holds the per-peripheral
// clock-gate and reset vectors (with atomic set/clear and self-timed reset
// pulses), and routes incoming event IDs through N_EVT comparators into
// registered event pulses and sticky status bits.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   cfg_*_i / cfg_*_o   config bus: 5-bit word address, 32-bit data,
//                       rwn=1 read / rwn=0 write, always ready,
//                       combinational read data (0 when no read is active)
//   rst_value_o         per-peripheral reset = level vector | pulse bits
//   cg_value_o          per-peripheral clock enable
//   cg_core_o           OR of all clock enables
//   event_valid_i/data_i  incoming event strobe and 8-bit ID
//   event_ready_o       always 1, one event accepted per cycle
//   event_o             per-comparator single-cycle pulse, one cycle late
// -----------------------------------------------------------------------------
module udma_ctrl_mc #(
   parameter int N_PERIPH  = 16,  // 1..32
   parameter int N_EVT     = 4,   // 4, 8, 12 or 16
   parameter int RST_PULSE = 4    // >= 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [31:0]         cfg_data_i,
   input  logic [4:0]          cfg_addr_i,
   input  logic                cfg_valid_i,
   input  logic                cfg_rwn_i,
   output logic [31:0]         cfg_data_o,
   output logic                cfg_ready_o,
   output logic [N_PERIPH-1:0] rst_value_o,
   output logic [N_PERIPH-1:0] cg_value_o,
   output logic                cg_core_o,
   input  logic                event_valid_i,
   input  logic [7:0]          event_data_i,
   output logic                event_ready_o,
   output logic [N_EVT-1:0]    event_o
);

   localparam int CNT_W = $clog2(RST_PULSE + 1);
   localparam int N_CFG = N_EVT / 4;  // number of CFG_EVT words

   localparam logic [4:0] ADDR_CG        = 5'h00;
   localparam logic [4:0] ADDR_CG_SET    = 5'h01;
   localparam logic [4:0] ADDR_CG_CLR    = 5'h02;
   localparam logic [4:0] ADDR_RST       = 5'h03;
   localparam logic [4:0] ADDR_RST_PULSE = 5'h04;
   localparam logic [4:0] ADDR_EVT_STAT  = 5'h05;
   localparam logic [4:0] ADDR_EVT_MASK  = 5'h06;
   localparam logic [4:0] ADDR_CFG_EVT   = 5'h08;

   logic [N_PERIPH-1:0] cg_q;
   logic [N_PERIPH-1:0] rst_q;
   logic [N_PERIPH-1:0] pulse_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [N_EVT-1:0]    status_q;
   logic [N_EVT-1:0]    mask_q;
   logic [N_EVT-1:0]    event_q;
   logic [7:0]          evt_id_q [N_EVT];

   logic                wr_en;
   logic                rd_en;
   logic [N_PERIPH-1:0] wdata_p;
   logic                pulse_wr;
   logic [N_EVT-1:0]    status_clr;
   logic [N_EVT-1:0]    hit;

   assign wr_en   = cfg_valid_i & ~cfg_rwn_i;
   assign rd_en   = cfg_valid_i &  cfg_rwn_i;
   assign wdata_p = cfg_data_i[N_PERIPH-1:0];

   // A pulse write with no bits in range is a no-op: neither bits nor timer change.
   assign pulse_wr   = wr_en && (cfg_addr_i == ADDR_RST_PULSE) && (wdata_p != '0);
   assign status_clr = (wr_en && (cfg_addr_i == ADDR_EVT_STAT)) ? cfg_data_i[N_EVT-1:0] : '0;

   // NOTE: every signal written in always_comb gets a default first so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      hit = '0;
      for (int i = 0; i < N_EVT; i++) begin
         hit[i] = event_valid_i && (event_data_i == evt_id_q[i]);
      end
   end

   // Clock-gate and level-reset vectors, event mask.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cg_q   <= '0;
         rst_q  <= '0;
         mask_q <= '0;
      end else if (wr_en) begin
         case (cfg_addr_i)
            ADDR_CG:       cg_q   <= wdata_p;
            ADDR_CG_SET:   cg_q   <= cg_q | wdata_p;
            ADDR_CG_CLR:   cg_q   <= cg_q & ~wdata_p;
            ADDR_RST:      rst_q  <= wdata_p;
            ADDR_EVT_MASK: mask_q <= cfg_data_i[N_EVT-1:0];
            default: ;
         endcase
      end
   end

   // Self-timed reset pulse: new bits are ORed in and the timer reloaded, so
   // the whole set is held RST_PULSE cycles from the most recent write. The
   // bits drop on the edge where the timer reaches 1.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pulse_q <= '0;
         cnt_q   <= '0;
      end else if (pulse_wr) begin
         pulse_q <= pulse_q | wdata_p;
         cnt_q   <= CNT_W'(RST_PULSE);
      end else if (cnt_q != '0) begin
         if (cnt_q == CNT_W'(1)) begin
            pulse_q <= '0;
         end
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Comparator IDs. 
   // NOTE: this small register array is reset like any other register because
   // its contents are architecturally visible (readable and compared against
   // live events); leaving it unreset would fire spurious events after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_EVT; i++) begin
            evt_id_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < N_CFG; k++) begin
            if (cfg_addr_i == 5'(ADDR_CFG_EVT + k)) begin
               for (int j = 0; j < 4; j++) begin
                  evt_id_q[4*k+j] <= cfg_data_i[8*j +: 8];
               end
            end
         end
      end
   end

   // Sticky status (a new hit beats a same-cycle clear) and registered pulses.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         status_q <= '0;
         event_q  <= '0;
      end else begin
         status_q <= (status_q & ~status_clr) | hit;
         event_q  <= hit & mask_q;
      end
   end

   // Combinational read mux; unused upper bits and unmapped addresses read 0.
   always_comb begin
      cfg_data_o = '0;
      if (rd_en) begin
         case (cfg_addr_i)
            ADDR_CG:        cfg_data_o[N_PERIPH-1:0] = cg_q;
            ADDR_RST:       cfg_data_o[N_PERIPH-1:0] = rst_q;
            ADDR_RST_PULSE: cfg_data_o[N_PERIPH-1:0] = pulse_q;
            ADDR_EVT_STAT:  cfg_data_o[N_EVT-1:0]    = status_q;
            ADDR_EVT_MASK:  cfg_data_o[N_EVT-1:0]    = mask_q;
            default: ;
         endcase
         for (int k = 0; k < N_CFG; k++) begin
            if (cfg_addr_i == 5'(ADDR_CFG_EVT + k)) begin
               for (int j = 0; j < 4; j++) begin
                  cfg_data_o[8*j +: 8] = evt_id_q[4*k+j];
               end
            end
         end
      end
   end

   assign cfg_ready_o   = 1'b1;
   assign event_ready_o = 1'b1;
   assign cg_value_o    = cg_q;
   assign cg_core_o     = |cg_q;
   assign rst_value_o   = rst_q | pulse_q;
   assign event_o       = event_q;

endmodule

// File: tb/tb_udma_ctrl_mc.sv
// -----------------------------------------------------------------------------
// tb_udma_ctrl_mc
// Directed bench for udma_ctrl_mc. Two instances share every input: dut uses
// the default parameters (16 peripherals, 4 comparators), dut2 uses
// 32 peripherals and 8 comparators. Inputs change on the falling edge and
// outputs are sampled there too, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_udma_ctrl_mc;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] cfg_data_i;
   logic [4:0]  cfg_addr_i;
   logic        cfg_valid_i;
   logic        cfg_rwn_i;
   logic        event_valid_i;
   logic [7:0]  event_data_i;

   logic [31:0] cfg_data_o,  cfg_data2_o;
   logic        cfg_ready_o, cfg_ready2_o;
   logic [15:0] rst_value_o, cg_value_o;
   logic [31:0] rst_value2_o, cg_value2_o;
   logic        cg_core_o,   cg_core2_o;
   logic        event_ready_o, event_ready2_o;
   logic [3:0]  event_o;
   logic [7:0]  event2_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] rd1, rd2;

   always #5 clk_i = ~clk_i;

   udma_ctrl_mc dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_data_i   (cfg_data_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_rwn_i    (cfg_rwn_i),
      .cfg_data_o   (cfg_data_o),
      .cfg_ready_o  (cfg_ready_o),
      .rst_value_o  (rst_value_o),
      .cg_value_o   (cg_value_o),
      .cg_core_o    (cg_core_o),
      .event_valid_i(event_valid_i),
      .event_data_i (event_data_i),
      .event_ready_o(event_ready_o),
      .event_o      (event_o)
   );

   udma_ctrl_mc #(.N_PERIPH(32), .N_EVT(8), .RST_PULSE(4)) dut2 (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_data_i   (cfg_data_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_rwn_i    (cfg_rwn_i),
      .cfg_data_o   (cfg_data2_o),
      .cfg_ready_o  (cfg_ready2_o),
      .rst_value_o  (rst_value2_o),
      .cg_value_o   (cg_value2_o),
      .cg_core_o    (cg_core2_o),
      .event_valid_i(event_valid_i),
      .event_data_i (event_data_i),
      .event_ready_o(event_ready2_o),
      .event_o      (event2_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk_i);
      cfg_valid_i = 1'b1;
      cfg_rwn_i   = 1'b0;
      cfg_addr_i  = addr;
      cfg_data_i  = data;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      cfg_data_i  = '0;
   endtask

   task automatic cfg_read(input logic [4:0] addr, output logic [31:0] d1, output logic [31:0] d2);
      @(negedge clk_i);
      cfg_valid_i = 1'b1;
      cfg_rwn_i   = 1'b1;
      cfg_addr_i  = addr;
      #1;
      d1 = cfg_data_o;
      d2 = cfg_data2_o;
      cfg_valid_i = 1'b0;
      cfg_rwn_i   = 1'b0;
   endtask

   initial begin
      logic [4:0] mapped [8];
      mapped = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08};

      rst_i         = 1'b1;
      cfg_data_i    = '0;
      cfg_addr_i    = '0;
      cfg_valid_i   = 1'b0;
      cfg_rwn_i     = 1'b0;
      event_valid_i = 1'b0;
      event_data_i  = '0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      // ---- reset state
      for (int i = 0; i < 8; i++) begin
         cfg_read(mapped[i], rd1, rd2);
         check($sformatf("rst_rd_%02h", mapped[i]), rd1, 32'h0);
      end
      check("rst_event_o",     32'(event_o),       32'h0);
      check("rst_rst_value",   32'(rst_value_o),   32'h0);
      check("rst_cg_core",     32'(cg_core_o),     32'h0);
      check("rst_cfg_ready",   32'(cfg_ready_o),   32'h1);
      check("rst_event_ready", 32'(event_ready_o), 32'h1);

      // ---- clock gate with atomic set/clear
      cfg_write(5'h00, 32'h0000_00F0);
      cfg_write(5'h01, 32'h0000_0003);
      cfg_write(5'h02, 32'h0000_0010);
      cfg_read(5'h00, rd1, rd2);
      check("cg_rd",       rd1, 32'h0000_00E3);
      check("cg_rd_w32",   rd2, 32'h0000_00E3);
      check("cg_value",    32'(cg_value_o), 32'h0000_00E3);
      check("cg_core_on",  32'(cg_core_o),  32'h1);
      cfg_read(5'h01, rd1, rd2);
      check("cg_set_rd0",  rd1, 32'h0);
      check("idle_rdata0", cfg_data_o, 32'h0);
      cfg_write(5'h02, 32'h0000_FFFF);
      check("cg_core_off", 32'(cg_core_o), 32'h0);

      // ---- level reset vector
      cfg_write(5'h03, 32'h0000_0100);
      cfg_read(5'h03, rd1, rd2);
      check("rst_lvl_rd",  rd1, 32'h0000_0100);
      check("rst_lvl_out", 32'(rst_value_o), 32'h0000_0100);
      cfg_write(5'h03, 32'h0);
      check("rst_lvl_clr", 32'(rst_value_o), 32'h0);

      // ---- single reset pulse: visible 4 cycles after the write edge
      @(negedge clk_i);
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h04; cfg_data_i = 32'h5;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_i);
         cfg_valid_i = 1'b0;
         check($sformatf("pulse1_c%0d", i), 32'(rst_value_o), (i <= 4) ? 32'h5 : 32'h0);
      end

      // ---- overlapping pulse: second write 2 edges later reloads the timer
      @(negedge clk_i);
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h04; cfg_data_i = 32'h5;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk_i);
         cfg_valid_i = 1'b0;
         check($sformatf("pulse2_c%0d", i), 32'(rst_value_o),
               (i <= 2) ? 32'h5 : ((i <= 6) ? 32'h7 : 32'h0));
         if (i == 2) begin
            cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h04; cfg_data_i = 32'h2;
         end
         if (i == 3) begin
            cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = 5'h04;
            #1;
            check("pulse2_rd", cfg_data_o, 32'h7);
            cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
         end
      end

      // ---- zero pulse write does nothing
      cfg_write(5'h04, 32'h0);
      check("pulse_zero", 32'(rst_value_o), 32'h0);

      // ---- asynchronous reset in the middle of a pulse
      @(negedge clk_i);
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h04; cfg_data_i = 32'h5;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      check("midrst_pre", 32'(rst_value_o), 32'h5);
      #2 rst_i = 1'b1;
      #1;
      check("midrst_async", 32'(rst_value_o), 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("midrst_after", 32'(rst_value_o), 32'h0);

      // ---- event routing: ids {0A,0A,05,03}, mask 0x5
      cfg_write(5'h08, 32'h0A0A_0503);
      cfg_write(5'h06, 32'h5);
      @(negedge clk_i);
      event_valid_i = 1'b1; event_data_i = 8'h03;
      @(negedge clk_i);
      event_data_i = 8'h0A;
      check("evt_p1", 32'(event_o), 32'h1);
      @(negedge clk_i);
      event_valid_i = 1'b0; event_data_i = 8'h00;
      check("evt_p2", 32'(event_o), 32'h4);
      @(negedge clk_i);
      check("evt_single", 32'(event_o), 32'h0);
      cfg_read(5'h05, rd1, rd2);
      check("evt_status", rd1, 32'hD);

      // ---- W1C collides with a new hit on comparator 1: set wins
      @(negedge clk_i);
      cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h05; cfg_data_i = 32'hF;
      event_valid_i = 1'b1; event_data_i = 8'h05;
      @(negedge clk_i);
      cfg_valid_i = 1'b0; event_valid_i = 1'b0; event_data_i = 8'h00;
      check("w1c_masked_evt", 32'(event_o), 32'h0);
      cfg_read(5'h05, rd1, rd2);
      check("w1c_set_wins", rd1, 32'h2);
      check("w1c_set_w32",  rd2, 32'h2);
      cfg_write(5'h05, 32'h2);
      cfg_read(5'h05, rd1, rd2);
      check("w1c_clear", rd1, 32'h0);

      // ---- 8 comparators / 32 peripherals on dut2
      cfg_write(5'h09, 32'h1122_3344);
      cfg_write(5'h06, 32'h40);
      @(negedge clk_i);
      event_valid_i = 1'b1; event_data_i = 8'h22;
      @(negedge clk_i);
      event_valid_i = 1'b0; event_data_i = 8'h00;
      check("w32_evt6",   32'(event2_o), 32'h40);
      check("w16_no_evt", 32'(event_o),  32'h0);
      cfg_read(5'h05, rd1, rd2);
      check("w32_status", rd2, 32'h40);
      cfg_read(5'h09, rd1, rd2);
      check("w32_cfg1_rd",   rd2, 32'h1122_3344);
      check("w16_cfg1_umap", rd1, 32'h0);
      cfg_read(5'h0A, rd1, rd2);
      check("w32_0A_rd0", rd2, 32'h0);
      cfg_read(5'h07, rd1, rd2);
      check("umap_07", rd1, 32'h0);
      cfg_write(5'h00, 32'hFFFF_FFFF);
      cfg_read(5'h00, rd1, rd2);
      check("w32_cg_full", rd2, 32'hFFFF_FFFF);
      check("w16_cg_trim", rd1, 32'h0000_FFFF);
      check("w32_cg_core", 32'(cg_core2_o), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
